// File: rtl/alu_op_ctrl.sv
// Front-end controller for the ALU datapath: accepts one operation per handshake,
// issues a one-cycle unit enable, waits for the unit flag and returns the result.
module alu_op_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic [WIDTH-1:0] Op_A,
  output logic [WIDTH-1:0] Op_B,
  output logic [1:0]       Unit_FUN,
  output logic             Arith_Enable,
  output logic             Logic_Enable,
  output logic             CMP_Enable,
  output logic             SHIFT_Enable,
  input  logic [WIDTH-1:0] Arith_OUT,
  input  logic [WIDTH-1:0] Logic_OUT,
  input  logic [WIDTH-1:0] CMP_OUT,
  input  logic [WIDTH-1:0] SHIFT_OUT,
  input  logic             Arith_Flag,
  input  logic             Logic_Flag,
  input  logic             CMP_Flag,
  input  logic             SHIFT_Flag,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             ERR
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t           state_r;
  logic [1:0]       sel_r;
  logic [3:0]       cnt_r;
  logic             sel_flag_s;
  logic [WIDTH-1:0] sel_out_s;

  // Ready to accept only while idle; combinational so a held request is taken on the first idle edge.
  always_comb begin
    if (state_r == S_IDLE) begin
      IN_READY = 1'b1;
    end else begin
      IN_READY = 1'b0;
    end
  end

  // Route the flag and result of the unit selected at accept; other units are ignored.
  always_comb begin
    sel_flag_s = 1'b0;
    sel_out_s  = {WIDTH{1'b0}};
    case (sel_r)
      2'b00: begin
        sel_flag_s = Arith_Flag;
        sel_out_s  = Arith_OUT;
      end
      2'b01: begin
        sel_flag_s = Logic_Flag;
        sel_out_s  = Logic_OUT;
      end
      2'b10: begin
        sel_flag_s = CMP_Flag;
        sel_out_s  = CMP_OUT;
      end
      2'b11: begin
        sel_flag_s = SHIFT_Flag;
        sel_out_s  = SHIFT_OUT;
      end
      default: begin
        sel_flag_s = 1'b0;
        sel_out_s  = {WIDTH{1'b0}};
      end
    endcase
  end

  // Operation sequencer: accept, one-cycle issue, bounded wait, hold result until consumed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r      <= S_IDLE;
      sel_r        <= 2'b00;
      cnt_r        <= 4'd0;
      Op_A         <= {WIDTH{1'b0}};
      Op_B         <= {WIDTH{1'b0}};
      Unit_FUN     <= 2'b00;
      Arith_Enable <= 1'b0;
      Logic_Enable <= 1'b0;
      CMP_Enable   <= 1'b0;
      SHIFT_Enable <= 1'b0;
      ALU_OUT      <= {WIDTH{1'b0}};
      OUT_VALID    <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (IN_VALID) begin
            Op_A         <= A;
            Op_B         <= B;
            Unit_FUN     <= ALU_FUN[1:0];
            sel_r        <= ALU_FUN[3:2];
            Arith_Enable <= (ALU_FUN[3:2] == 2'b00);
            Logic_Enable <= (ALU_FUN[3:2] == 2'b01);
            CMP_Enable   <= (ALU_FUN[3:2] == 2'b10);
            SHIFT_Enable <= (ALU_FUN[3:2] == 2'b11);
            state_r      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          Arith_Enable <= 1'b0;
          Logic_Enable <= 1'b0;
          CMP_Enable   <= 1'b0;
          SHIFT_Enable <= 1'b0;
          cnt_r        <= 4'd0;
          state_r      <= S_WAIT;
        end
        S_WAIT: begin
          if (sel_flag_s) begin
            ALU_OUT   <= sel_out_s;
            ERR       <= 1'b0;
            OUT_VALID <= 1'b1;
            state_r   <= S_DONE;
          end else if (cnt_r == CNT_LAST) begin
            // Unit never answered: report a zero result flagged as an error.
            ALU_OUT   <= {WIDTH{1'b0}};
            ERR       <= 1'b1;
            OUT_VALID <= 1'b1;
            state_r   <= S_DONE;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        S_DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Directed bench for alu_op_ctrl: the bench plays the four units by hand and
// checks handshake timing, result capture, backpressure, timeout and reset abort.
module tb_alu_op_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] A = 16'h0000;
  logic [15:0] B = 16'h0000;
  logic [3:0]  ALU_FUN = 4'h0;
  logic [15:0] Op_A, Op_B;
  logic [1:0]  Unit_FUN;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
  logic [15:0] Arith_OUT = 16'h0000;
  logic [15:0] Logic_OUT = 16'h0000;
  logic [15:0] CMP_OUT = 16'h0000;
  logic [15:0] SHIFT_OUT = 16'h0000;
  logic        Arith_Flag = 1'b0;
  logic        Logic_Flag = 1'b0;
  logic        CMP_Flag = 1'b0;
  logic        SHIFT_Flag = 1'b0;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic        ERR;

  int vectors = 0;
  int miscompares = 0;

  alu_op_ctrl #(.WIDTH(16), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Op_A(Op_A), .Op_B(Op_B), .Unit_FUN(Unit_FUN),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
    .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
    .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge before checking or driving.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 32'(OUT_VALID), 32'h0);
    check("rst_alu_out", 32'(ALU_OUT), 32'h0);
    check("rst_enables", 32'({Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}), 32'h0);
    check("rst_ops", 32'({Op_A, Op_B}), 32'h0);
    tick();
    RST = 1'b1;
    tick();
    check("rst_in_ready", 32'(IN_READY), 32'h1);

    // Logic AND: 00F0 & 0FF0 = 00F0
    IN_VALID = 1'b1; ALU_FUN = 4'b0100; A = 16'h00F0; B = 16'h0FF0; OUT_READY = 1'b1;
    tick();
    IN_VALID = 1'b0;
    check("and_enables", 32'({Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}), 32'h4);
    check("and_unit_fun", 32'(Unit_FUN), 32'h0);
    check("and_op_a", 32'(Op_A), 32'h00F0);
    check("and_op_b", 32'(Op_B), 32'h0FF0);
    check("and_in_ready", 32'(IN_READY), 32'h0);
    tick();
    check("and_enable_drop", 32'(Logic_Enable), 32'h0);
    check("and_no_early_valid", 32'(OUT_VALID), 32'h0);
    Logic_OUT = 16'h00F0; Logic_Flag = 1'b1;
    tick();
    Logic_Flag = 1'b0;
    check("and_out_valid", 32'(OUT_VALID), 32'h1);
    check("and_alu_out", 32'(ALU_OUT), 32'h00F0);
    check("and_err", 32'(ERR), 32'h0);
    tick();
    check("and_consumed", 32'(OUT_VALID), 32'h0);
    check("and_idle", 32'(IN_READY), 32'h1);

    // Logic NOR: ~(0000 | 00FF) = FF00
    IN_VALID = 1'b1; ALU_FUN = 4'b0111; A = 16'h0000; B = 16'h00FF;
    tick();
    IN_VALID = 1'b0;
    check("nor_unit_fun", 32'(Unit_FUN), 32'h3);
    check("nor_enable", 32'(Logic_Enable), 32'h1);
    tick();
    Logic_OUT = 16'hFF00; Logic_Flag = 1'b1;
    tick();
    Logic_Flag = 1'b0;
    check("nor_alu_out", 32'(ALU_OUT), 32'hFF00);
    check("nor_out_valid", 32'(OUT_VALID), 32'h1);
    tick();

    // Backpressure: arith add 5+3 held 5 cycles, next op (cmp) held on IN_VALID
    IN_VALID = 1'b1; ALU_FUN = 4'b0000; A = 16'h0005; B = 16'h0003; OUT_READY = 1'b0;
    tick();
    check("bp_arith_enable", 32'(Arith_Enable), 32'h1);
    ALU_FUN = 4'b1000; A = 16'hFFFD; B = 16'h0007;
    tick();
    check("bp_op_a_stable", 32'(Op_A), 32'h0005);
    Arith_OUT = 16'h0008; Arith_Flag = 1'b1;
    tick();
    Arith_Flag = 1'b0;
    check("bp_first_valid", 32'(OUT_VALID), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(OUT_VALID), 32'h1);
      check("bp_hold_out", 32'(ALU_OUT), 32'h0008);
      check("bp_in_ready", 32'(IN_READY), 32'h0);
    end
    OUT_READY = 1'b1;
    tick();
    check("bp_released", 32'(OUT_VALID), 32'h0);
    check("bp_bubble_no_enable", 32'(CMP_Enable), 32'h0);
    check("bp_bubble_ready", 32'(IN_READY), 32'h1);
    tick();
    IN_VALID = 1'b0;
    check("bp_next_accept", 32'(CMP_Enable), 32'h1);
    check("bp_next_op_a", 32'(Op_A), 32'hFFFD);

    // Stray flag: Logic_Flag high must be ignored, capture on CMP_Flag 2 cycles late
    OUT_READY = 1'b0;
    tick();
    Logic_OUT = 16'hBEEF; Logic_Flag = 1'b1; CMP_OUT = 16'h0001;
    tick();
    check("stray_ignored_0", 32'(OUT_VALID), 32'h0);
    tick();
    check("stray_ignored_1", 32'(OUT_VALID), 32'h0);
    CMP_Flag = 1'b1;
    tick();
    CMP_Flag = 1'b0; Logic_Flag = 1'b0;
    check("stray_valid", 32'(OUT_VALID), 32'h1);
    check("stray_alu_out", 32'(ALU_OUT), 32'h0001);
    check("stray_err", 32'(ERR), 32'h0);
    OUT_READY = 1'b1;
    tick();

    // Timeout: arith never flags, result after ISSUE + 4 WAIT cycles
    IN_VALID = 1'b1; ALU_FUN = 4'b0000; A = 16'h1111; B = 16'h2222; Arith_OUT = 16'h1234;
    tick();
    IN_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_not_yet", 32'(OUT_VALID), 32'h0);
    end
    tick();
    check("to_valid", 32'(OUT_VALID), 32'h1);
    check("to_err", 32'(ERR), 32'h1);
    check("to_alu_out", 32'(ALU_OUT), 32'h0);
    tick();
    check("to_consumed", 32'(OUT_VALID), 32'h0);

    // Reset during WAIT aborts asynchronously
    IN_VALID = 1'b1; ALU_FUN = 4'b1110; A = 16'hA5A5; B = 16'h0004;
    tick();
    IN_VALID = 1'b0;
    check("rw_shift_enable", 32'(SHIFT_Enable), 32'h1);
    tick();
    #2;
    RST = 1'b0;
    #1;
    check("rw_ops_cleared", 32'({Op_A, Op_B}), 32'h0);
    check("rw_unit_fun", 32'(Unit_FUN), 32'h0);
    check("rw_out_cleared", 32'({ALU_OUT, OUT_VALID, ERR}), 32'h0);
    tick();
    RST = 1'b1;
    SHIFT_OUT = 16'h5A50; SHIFT_Flag = 1'b1;
    tick();
    check("rw_in_ready", 32'(IN_READY), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rw_no_valid", 32'(OUT_VALID), 32'h0);
    end
    SHIFT_Flag = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
